// File: rtl/cpu_clk_sequencer.sv
// Run/halt/single-step/burst controller producing a registered clock enable for the core.
// The core stays on clk and advances only on cycles where cpu_en is high.
module cpu_clk_sequencer #(
  parameter int DIV_W      = 8,
  parameter int CNT_W      = 16,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             step_btn,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic [31:0]      cycle_cnt
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_SWAIT = 2'd2,
    S_BURST = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             btn_s1_q, btn_s1_d;
  logic             btn_s2_q, btn_s2_d;
  logic             acc_q, acc_d;
  logic             cpu_en_q, cpu_en_d;
  logic             done_q, done_d;
  logic [31:0]      cycle_cnt_q, cycle_cnt_d;
  logic             tick;

  // Debounce saturates at DEB_MAX so a held button yields a single accept pulse.
  always_comb begin
    btn_s1_d = step_btn;
    btn_s2_d = btn_s1_q;
    if (!btn_s2_q) begin
      deb_d = '0;
    end else if (deb_q != DEB_MAX) begin
      deb_d = deb_q + DEB_W'(1);
    end else begin
      deb_d = deb_q;
    end
    acc_d = (deb_d == DEB_MAX) && (deb_q != DEB_MAX);
  end

  assign tick = (presc_q == div);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    burst_d     = burst_q;
    cpu_en_d    = 1'b0;
    done_d      = 1'b0;
    cycle_cnt_d = cycle_cnt_q + {31'b0, cpu_en_q};
    case (state_q)
      S_IDLE: begin
        // Holding the prescaler at zero here clears it on every RUN/BURST entry.
        presc_d = '0;
        if (mode == MODE_RUN) begin
          state_d = S_RUN;
        end else if (mode == MODE_STEP && acc_q) begin
          cpu_en_d = 1'b1;
          state_d  = S_SWAIT;
        end else if (mode == MODE_BURST && start && burst_len != '0) begin
          burst_d = burst_len;
          state_d = S_BURST;
        end
      end
      S_RUN: begin
        if (mode != MODE_RUN) begin
          state_d = S_IDLE;
        end else begin
          presc_d  = tick ? '0 : presc_q + DIV_W'(1);
          cpu_en_d = tick;
        end
      end
      S_SWAIT: begin
        if (!btn_s2_q) state_d = S_IDLE;
      end
      S_BURST: begin
        if (mode == MODE_HALT) begin
          state_d = S_IDLE;
        end else begin
          presc_d = tick ? '0 : presc_q + DIV_W'(1);
          if (tick) begin
            cpu_en_d = 1'b1;
            burst_d  = burst_q - CNT_W'(1);
            if (burst_q == CNT_W'(1)) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      burst_q     <= '0;
      deb_q       <= '0;
      btn_s1_q    <= 1'b0;
      btn_s2_q    <= 1'b0;
      acc_q       <= 1'b0;
      cpu_en_q    <= 1'b0;
      done_q      <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      burst_q     <= burst_d;
      deb_q       <= deb_d;
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
      acc_q       <= acc_d;
      cpu_en_q    <= cpu_en_d;
      done_q      <= done_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cpu_en    = cpu_en_q;
  assign done      = done_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_BURST);
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_clk_sequencer.sv
// Directed bench for cpu_clk_sequencer: reset, RUN rates, debounced STEP, BURST, abort, wrap.
module tb_cpu_clk_sequencer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic [7:0]  div;
  logic        step_btn;
  logic        start;
  logic [15:0] burst_len;
  logic        cpu_en;
  logic        busy;
  logic        done;
  logic [31:0] cycle_cnt;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int done_cnt = 0;
  int consec_cnt = 0;
  logic prev_en = 1'b0;
  logic [31:0] exp_cyc;
  int base_p, base_d;

  cpu_clk_sequencer #(.DIV_W(8), .CNT_W(16), .DEB_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .div       (div),
    .step_btn  (step_btn),
    .start     (start),
    .burst_len (burst_len),
    .cpu_en    (cpu_en),
    .busy      (busy),
    .done      (done),
    .cycle_cnt (cycle_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse/done monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (cpu_en === 1'b1) pulse_cnt <= pulse_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (cpu_en === 1'b1 && prev_en === 1'b1 && div != 8'd0) consec_cnt <= consec_cnt + 1;
    prev_en <= cpu_en;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b1; mode = 2'b00; div = 8'd3; step_btn = 1'b0; start = 1'b0; burst_len = 16'd0;
    exp_cyc = 32'd0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_cpu_en", {31'b0, cpu_en}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // RUN div=3: one pulse every 4 cycles, first at the 4th edge after entry
    base_p = pulse_cnt;
    mode = 2'b01;
    for (int i = 1; i <= 42; i++) begin
      @(negedge clk);
      check("run_div3_en", {31'b0, cpu_en}, {31'b0, (i >= 5) && ((i - 5) % 4 == 0)});
      if (i == 20) check("run_busy", {31'b0, busy}, 32'd1);
    end
    mode = 2'b00;
    repeat (3) @(negedge clk);
    check("run_pulses", 32'(pulse_cnt - base_p), 32'd10);
    exp_cyc = exp_cyc + 32'd10;
    check("run_cycle_cnt", cycle_cnt, exp_cyc);
    check("run_busy_off", {31'b0, busy}, 32'd0);

    // RUN div=0: enable every cycle, then asynchronous reset mid-run
    div = 8'd0;
    mode = 2'b01;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("run_div0_en", {31'b0, cpu_en}, 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cpu_en", {31'b0, cpu_en}, 32'd0);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_done", {31'b0, done}, 32'd0);
    check("async_rst_cycle_cnt", cycle_cnt, 32'd0);
    @(negedge clk);
    mode = 2'b00;
    div = 8'd3;
    rst_n = 1'b1;
    exp_cyc = 32'd0;
    repeat (2) @(negedge clk);

    // STEP: bouncy press then long hold -> one pulse
    mode = 2'b10;
    base_p = pulse_cnt;
    for (int k = 0; k < 4; k++) begin
      step_btn = 1'b1; @(negedge clk);
      step_btn = 1'b0; @(negedge clk);
    end
    step_btn = 1'b1;
    repeat (50) @(negedge clk);
    step_btn = 1'b0;
    repeat (6) @(negedge clk);
    check("step_bouncy_pulses", 32'(pulse_cnt - base_p), 32'd1);
    exp_cyc = exp_cyc + 32'd1;
    check("step_cycle_cnt", cycle_cnt, exp_cyc);

    // STEP: glitch shorter than the debounce window -> nothing
    base_p = pulse_cnt;
    step_btn = 1'b1;
    repeat (3) @(negedge clk);
    step_btn = 1'b0;
    repeat (8) @(negedge clk);
    check("step_glitch_pulses", 32'(pulse_cnt - base_p), 32'd0);

    // STEP: clean press, pulse lands on the 7th edge after the press
    base_p = pulse_cnt;
    step_btn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("step_latency_en", {31'b0, cpu_en}, {31'b0, i == 7});
    end
    repeat (10) @(negedge clk);
    step_btn = 1'b0;
    repeat (6) @(negedge clk);
    check("step_second_pulses", 32'(pulse_cnt - base_p), 32'd1);
    exp_cyc = exp_cyc + 32'd1;
    check("step2_cycle_cnt", cycle_cnt, exp_cyc);

    // BURST div=1 len=5
    mode = 2'b11; div = 8'd1; burst_len = 16'd5;
    @(negedge clk);
    base_d = done_cnt;
    start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      check("burst_en", {31'b0, cpu_en}, {31'b0, (i >= 3) && (i <= 11) && (i % 2 == 1)});
      check("burst_done", {31'b0, done}, {31'b0, i == 11});
      check("burst_busy", {31'b0, busy}, {31'b0, i <= 10});
    end
    repeat (2) @(negedge clk);
    exp_cyc = exp_cyc + 32'd5;
    check("burst_cycle_cnt", cycle_cnt, exp_cyc);
    check("burst_done_count", 32'(done_cnt - base_d), 32'd1);

    // BURST with burst_len=0 is ignored
    base_p = pulse_cnt;
    base_d = done_cnt;
    burst_len = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("burst0_busy", {31'b0, busy}, 32'd0);
    end
    check("burst0_pulses", 32'(pulse_cnt - base_p), 32'd0);
    check("burst0_done", 32'(done_cnt - base_d), 32'd0);

    // BURST len=100 aborted by HALT after 3 pulses; start mid-burst ignored
    base_p = pulse_cnt;
    base_d = done_cnt;
    burst_len = 16'd100;
    start = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 4) start = 1'b1;
      if (i == 5) start = 1'b0;
    end
    mode = 2'b00;
    repeat (20) @(negedge clk);
    check("abort_pulses", 32'(pulse_cnt - base_p), 32'd3);
    check("abort_done", 32'(done_cnt - base_d), 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    exp_cyc = exp_cyc + 32'd3;
    check("abort_cycle_cnt", cycle_cnt, exp_cyc);

    // cycle_cnt wrap
    @(negedge clk);
    force dut.cycle_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cycle_cnt_q;
    @(negedge clk);
    check("wrap_preload", cycle_cnt, 32'hFFFF_FFFF);
    div = 8'd3;
    mode = 2'b01;
    repeat (10) @(negedge clk);
    mode = 2'b00;
    repeat (3) @(negedge clk);
    check("wrap_cycle_cnt", cycle_cnt, 32'h0000_0001);

    check("no_back_to_back", 32'(consec_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
